// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper and its bench scoreboard.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Combination index {in1, in2, in3}.
  typedef logic [2:0] idx_t;

  // Combination 0 lands in the MSB of the table ID.
  function automatic logic [2:0] table_bit_pos(idx_t idx);
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_stability_detector.sv
// Synchronises the gate output and decides when a response bit is stable or has timed out.
module truth_table_sweeper_stability_detector #(
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_dut_out,
  input  logic i_active,
  output logic o_accept,
  output logic o_timeout,
  output logic o_value
);

  localparam int unsigned RunW = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [RunW-1:0] r_run;
  logic [TmoW-1:0] r_tmo;
  logic [RunW-1:0] w_run_next;
  logic [TmoW-1:0] w_tmo_next;

  // Two-flop synchroniser plus one-cycle history of the synchronised value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_dut_out;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Next run length and elapsed sample-phase cycles.
  always_comb begin
    w_run_next = (r_sync2 == r_prev) ? r_run + RunW'(1) : RunW'(1);
    w_tmo_next = r_tmo + TmoW'(1);
  end

  // Acceptance has priority over a timeout landing on the same cycle.
  assign o_accept  = i_active && (w_run_next == RunW'(STABLE_SAMPLES));
  assign o_timeout = i_active && !o_accept && (w_tmo_next == TmoW'(TIMEOUT_CYCLES));
  assign o_value   = r_sync2;

  // Counters run only in the sample phase and clear on leaving it, so they never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= '0;
      r_tmo <= '0;
    end else if (!i_active || o_accept || o_timeout) begin
      r_run <= '0;
      r_tmo <= '0;
    end else begin
      r_run <= w_run_next;
      r_tmo <= w_tmo_next;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 combinations and checks its measured truth-table ID.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  EXPECTED_ID    = 8'h1E
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_dut_out,
  output logic       o_in1,
  output logic       o_in2,
  output logic       o_in3,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_table_id,
  output logic [7:0] o_unstable_mask,
  output logic       o_pass
);

  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

  state_e          r_state;
  idx_t            r_idx;
  logic [SetW-1:0] r_settle;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_table;
  logic [7:0]      r_mask;
  logic            r_pass;

  logic       w_active;
  logic       w_accept;
  logic       w_timeout;
  logic       w_value;
  logic [2:0] w_pos;
  logic [7:0] w_table_upd;
  logic [7:0] w_mask_upd;

  assign w_active = (r_state == StSample);

  truth_table_sweeper_stability_detector #(
    .STABLE_SAMPLES(STABLE_SAMPLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stability_detector (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_dut_out(i_dut_out),
    .i_active (w_active),
    .o_accept (w_accept),
    .o_timeout(w_timeout),
    .o_value  (w_value)
  );

  // Table and mask as they will look once the current combination is resolved.
  always_comb begin
    w_pos       = table_bit_pos(r_idx);
    w_table_upd = r_table;
    w_mask_upd  = r_mask;
    if (w_accept) begin
      w_table_upd[w_pos] = w_value;
    end else if (w_timeout) begin
      w_table_upd[w_pos] = 1'b0;
      w_mask_upd[w_pos]  = 1'b1;
    end
  end

  // Sweep FSM with registered outputs; abort always wins over progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_settle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_table  <= '0;
      r_mask   <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start && !i_abort) begin
            r_table  <= '0;
            r_mask   <= '0;
            r_pass   <= 1'b0;
            r_idx    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b1;
            r_state  <= StSettle;
          end
        end
        StSettle: begin
          if (i_abort) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_idx    <= '0;
            r_settle <= '0;
            r_pass   <= 1'b0;
          end else if (r_settle == SetW'(SETTLE_CYCLES - 1)) begin
            r_settle <= '0;
            r_state  <= StSample;
          end else begin
            r_settle <= r_settle + SetW'(1);
          end
        end
        StSample: begin
          if (i_abort) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_idx    <= '0;
            r_settle <= '0;
            r_pass   <= 1'b0;
          end else if (w_accept || w_timeout) begin
            r_table <= w_table_upd;
            r_mask  <= w_mask_upd;
            if (r_idx == 3'd7) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_idx   <= '0;
              r_pass  <= (w_table_upd == EXPECTED_ID) && (w_mask_upd == 8'h00);
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= StSettle;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_in1           = r_idx[2];
  assign o_in2           = r_idx[1];
  assign o_in3           = r_idx[0];
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_table_id      = r_table;
  assign o_unstable_mask = r_mask;
  assign o_pass          = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper driving behavioural gate models on dut_out.
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] table_id;
  logic [7:0] unstable_mask;
  logic       pass;

  int n_checks = 0;
  int n_fails  = 0;

  // Gate models: 0 ideal 0x1E, 1 stuck at 1, 2 delayed 0x1E with glitch, 3 toggling at idx 2.
  int   mode = 0;
  logic glitch = 1'b0;
  logic tog;
  logic gate_ideal;
  logic gate_dly = 1'b0;

  int hook_glitch = -1;
  int hook_start  = -1;

  truth_table_sweeper dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_dut_out      (dut_out),
    .o_in1          (in1),
    .o_in2          (in2),
    .o_in3          (in3),
    .o_busy         (busy),
    .o_done         (done),
    .o_table_id     (table_id),
    .o_unstable_mask(unstable_mask),
    .o_pass         (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign gate_ideal = in1 ^ (in2 & in3);

  // 30 time-unit propagation delay; inputs change far less often than that.
  always begin
    @(gate_ideal);
    #30;
    gate_dly = gate_ideal;
  end

  always_ff @(posedge clk) begin
    if (mode == 3 && {in1, in2, in3} == 3'd2) tog <= ~tog;
    else tog <= 1'b0;
  end

  always_comb begin
    case (mode)
      1:       dut_out = 1'b1;
      2:       dut_out = gate_dly ^ glitch;
      3:       dut_out = gate_ideal ^ tog;
      default: dut_out = gate_ideal;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start pulse accepted on the next edge (cycle 0).
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges after launch until done is seen, applying glitch/start hooks.
  task automatic sweep(input int limit, output int n);
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      step();
      n++;
      if (n == hook_glitch) glitch = 1'b1;
      if (n == hook_glitch + 1) glitch = 1'b0;
      if (n == hook_start) start = 1'b1;
      if (n == hook_start + 1) start = 1'b0;
      if (done) got = 1'b1;
    end
  endtask

  initial begin
    int          n;
    int          dones;
    logic [7:0]  exp_mask;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #22;
    check("reset_busy", busy, 0);
    check("reset_outs", {done, pass, in1, in2, in3, table_id, unstable_mask}, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Ideal 0x1E gate with input stepping checks.
    mode = 0;
    launch();
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
      if (n == 1) check("t1_busy", busy, 1);
      if (n == 19) check("t1_in_idx0", {in1, in2, in3}, 0);
      if (n == 20) check("t1_in_idx1", {in1, in2, in3}, 1);
      if (n == 140) check("t1_in_idx7", {in1, in2, in3}, 7);
    end
    check("t1_latency", n, 160);
    check("t1_table", table_id, 8'h1E);
    check("t1_mask", unstable_mask, 0);
    check("t1_pass", pass, 1);
    check("t1_busy_done", busy, 0);
    check("t1_in_done", {in1, in2, in3}, 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_pass_hold", pass, 1);
    repeat (4) step();

    // Stuck-at-1 gate.
    mode = 1;
    repeat (4) step();
    launch();
    sweep(400, n);
    check("t2_latency", n, 160);
    check("t2_table", table_id, 8'hFF);
    check("t2_pass", pass, 0);
    repeat (4) step();

    // Delayed gate, one-cycle glitch sampled on the first sample edge of idx 5 plus one.
    // The glitch restarts the run twice: acceptance slips by 3 cycles.
    mode = 2;
    repeat (4) step();
    hook_glitch = 116;
    launch();
    sweep(400, n);
    hook_glitch = -1;
    check("t3_latency", n, 163);
    check("t3_table", table_id, 8'h1E);
    check("t3_mask", unstable_mask, 0);
    check("t3_pass", pass, 1);
    repeat (4) step();

    // Output toggling every cycle at idx 2: that slot times out after 64 sample cycles.
    mode = 3;
    repeat (4) step();
    launch();
    sweep(400, n);
    exp_mask = 8'h01 << table_bit_pos(3'd2);
    check("t4_latency", n, 220);
    check("t4_mask", unstable_mask, exp_mask);
    check("t4_mask_const", unstable_mask, 8'h20);
    check("t4_table", table_id, 8'h1E);
    check("t4_pass", pass, 0);
    repeat (4) step();

    // Abort at cycle 50 (idx 2), then a full rerun.
    mode = 0;
    repeat (4) step();
    launch();
    repeat (50) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_in", {in1, in2, in3}, 0);
    check("t5_done", done, 0);
    check("t5_partial", {table_id, unstable_mask}, 0);
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) dones++;
    end
    check("t5_no_done", dones, 0);
    check("t5_idle", busy, 0);
    launch();
    sweep(400, n);
    check("t5_rerun_latency", n, 160);
    check("t5_rerun_pass", pass, 1);
    repeat (4) step();

    // Abort and start together in idle: nothing starts. Abort alone in idle: no effect.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b0;
    check("t6_no_start", busy, 0);
    check("t6_pass_kept", pass, 1);

    // Reset mid-sweep at cycle 70 with the stuck-at-1 gate.
    mode = 1;
    repeat (4) step();
    launch();
    repeat (70) step();
    check("t7_partial", table_id, 8'hE0);
    check("t7_in", {in1, in2, in3}, 3);
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_outs", {done, pass, in1, in2, in3, table_id, unstable_mask}, 0);
    #2;
    rst_n = 1'b1;
    mode = 0;
    repeat (4) step();

    // Start pulsed while busy is ignored.
    hook_start = 30;
    launch();
    sweep(400, n);
    hook_start = -1;
    check("t7_latency", n, 160);
    check("t7_pass", pass, 1);
    step();
    check("t7_no_restart", busy, 0);
    repeat (4) step();

    // Start held high: relaunch one cycle after the done cycle.
    start = 1'b1;
    step();
    sweep(400, n);
    check("t8_latency", n, 160);
    step();
    check("t8_idle_gap", busy, 0);
    step();
    check("t8_relaunch", busy, 1);
    check("t8_relaunch_in", {in1, in2, in3}, 0);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t8_abort", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
